// File: rtl/rr_mux_sched_pkg.sv
// Shared types and helpers for the rr_mux_sched round-robin scheduler.
package rr_mux_sched_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int DEF_MAX_HOLD = 4;

  // Ceiling log2, floored at 1 so a single-entry index still has a bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/rr_mux_sched_pick.sv
// Combinational rotating-priority encoder: first set request after i_last, wrapping.
module rr_pick
  import rr_mux_sched_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic [N_REQ-1:0] o_pick,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
  always_comb begin
    o_pick = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!o_any && i_req[(int'(i_last) + i) % N_REQ]) begin
        o_any = 1'b1;
        o_pick[(int'(i_last) + i) % N_REQ] = 1'b1;
        o_idx = IW'((int'(i_last) + i) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/rr_mux_sched.sv
// Round-robin N:1 scheduler: one-hot grant plus registered y = din[owner].
// Optional grant timeout is built when ARB_TIMEOUT_EN is defined.
module rr_mux_sched
  import rr_mux_sched_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int DW       = 1,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] din,
  output logic [N_REQ-1:0]    gnt,
  output logic                gnt_vld,
  output logic [DW-1:0]       y,
  output logic                y_vld
);

  localparam int IW = clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || MAX_HOLD < 1) begin : g_bad_param
    $error("rr_mux_sched: N_REQ must be 2..8 and MAX_HOLD >= 1");
  end

  state_e            r_state, w_state_nxt;
  logic [N_REQ-1:0]  r_gnt, w_gnt_nxt;
  logic [IW-1:0]     r_last, w_last_nxt;
  logic              r_gnt_vld;
  logic [DW-1:0]     r_y;
  logic              r_y_vld;

  logic [N_REQ-1:0]  w_pick_req, w_pick;
  logic [IW-1:0]     w_pick_idx;
  logic              w_pick_any;
  logic              w_owner_req;
  logic              w_new_grant;
  logic              w_timeout;
  logic [DW-1:0]     w_owner_din;

  // While granted the current owner is masked out so a hand-off always moves on.
  assign w_pick_req  = (r_state == ST_GRANT) ? (req & ~r_gnt) : req;
  assign w_owner_req = |(req & r_gnt);
  assign w_owner_din = din[int'(r_last)*DW +: DW];

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .i_req  (w_pick_req),
    .i_last (r_last),
    .o_pick (w_pick),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CW = clog2(MAX_HOLD) + 1;
  logic [CW-1:0] r_hold_cnt;

  assign w_timeout = (r_hold_cnt >= CW'(MAX_HOLD - 1));

  // Saturates at MAX_HOLD-1 so a late arrival preempts on the very next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else if (w_new_grant) begin
      r_hold_cnt <= '0;
    end else if (r_state == ST_GRANT && !w_timeout) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    w_new_grant = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_gnt_nxt   = w_pick;
          w_last_nxt  = w_pick_idx;
          w_new_grant = 1'b1;
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!w_owner_req || w_timeout) begin
          if (w_pick_any) begin
            w_gnt_nxt   = w_pick;
            w_last_nxt  = w_pick_idx;
            w_new_grant = 1'b1;
          end else if (!w_owner_req) begin
            w_gnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_gnt_vld <= 1'b0;
      r_last    <= IW'(N_REQ - 1);
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_vld <= |w_gnt_nxt;
      r_last    <= w_last_nxt;
    end
  end

  // NOTE: y keeps its value through an enable on a real flop, never an incomplete comb assignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y     <= '0;
      r_y_vld <= 1'b0;
    end else if (r_state == ST_GRANT) begin
      r_y     <= w_owner_din;
      r_y_vld <= 1'b1;
    end else begin
      r_y_vld <= 1'b0;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_vld = r_gnt_vld;
  assign y       = r_y;
  assign y_vld   = r_y_vld;

endmodule

// File: tb/tb_rr_mux_sched.sv
// Self-checking bench for rr_mux_sched: directed steps plus a reference-model scoreboard.
module tb_rr_mux_sched;
  import rr_mux_sched_pkg::*;

  localparam int N    = 3;
  localparam int DW   = 1;
  localparam int MH   = DEF_MAX_HOLD;
  localparam int DINW = N * DW;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req   = '0;
  logic [DINW-1:0] din   = '0;
  logic [N-1:0]    gnt;
  logic            gnt_vld;
  logic [DW-1:0]   y;
  logic            y_vld;

  rr_mux_sched #(
    .N_REQ    (N),
    .DW       (DW),
    .MAX_HOLD (MH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .din     (din),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .y       (y),
    .y_vld   (y_vld)
  );

  always #50 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic          gnt_vld;
    logic [DW-1:0] y;
    logic          y_vld;
  } exp_t;

  typedef struct {
    int            owner;
    int            last;
    int            cnt;
    logic [DW-1:0] y;
    logic          yvld;
  } mstate_t;

  localparam mstate_t M_RESET = '{owner: -1, last: N - 1, cnt: 0, y: '0, yvld: 1'b0};

  exp_t    sb_q[$];
  mstate_t m = M_RESET;
  int      n_tests = 0;
  int      n_fail  = 0;

  function automatic int next_after(input int start, input logic [N-1:0] r);
    for (int i = 1; i <= N; i++) begin
      if (r[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input logic [N-1:0] r,
                                         input logic [DINW-1:0] d);
    mstate_t      n;
    logic [N-1:0] others;
    n      = s;
    n.yvld = 1'b0;
    if (s.owner < 0) begin
      if (r != '0) begin
        n.owner = next_after(s.last, r);
        n.last  = n.owner;
        n.cnt   = 0;
      end
    end else begin
      n.y    = d[s.owner*DW +: DW];
      n.yvld = 1'b1;
      others = r;
      others[s.owner] = 1'b0;
      if (!r[s.owner]) begin
        if (others != '0) begin
          n.owner = next_after(s.owner, others);
          n.last  = n.owner;
          n.cnt   = 0;
        end else begin
          n.owner = -1;
        end
      end
`ifdef ARB_TIMEOUT_EN
      else if (s.cnt == MH - 1 && others != '0) begin
        n.owner = next_after(s.owner, others);
        n.last  = n.owner;
        n.cnt   = 0;
      end else if (s.cnt < MH - 1) begin
        n.cnt = s.cnt + 1;
      end
`endif
    end
    return n;
  endfunction

  function automatic exp_t to_exp(input mstate_t s);
    exp_t e;
    e.gnt = '0;
    if (s.owner >= 0) e.gnt[s.owner] = 1'b1;
    e.gnt_vld = (s.owner >= 0);
    e.y       = s.y;
    e.y_vld   = s.yvld;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= M_RESET;
      sb_q.delete();
    end else begin
      m <= model_next(m, req, din);
      sb_q.push_back(to_exp(model_next(m, req, din)));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_compare();
    exp_t e;
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check("sb_gnt",     32'(gnt),     32'(e.gnt));
    check("sb_gnt_vld", 32'(gnt_vld), 32'(e.gnt_vld));
    check("sb_y",       32'(y),       32'(e.y));
    check("sb_y_vld",   32'(y_vld),   32'(e.y_vld));
    check("sb_onehot",  32'($onehot0(gnt)), 1);
    check("sb_depth",   32'(sb_q.size()), 0);
  endtask

  task automatic cycle();
    @(negedge clk);
    sb_compare();
  endtask

  initial begin
    logic [N-1:0] e4;
    int           wait_c [N];
    int           max_w;

    // Reset state
    #120;
    check("rst_gnt",     32'(gnt),     0);
    check("rst_gnt_vld", 32'(gnt_vld), 0);
    check("rst_y",       32'(y),       0);
    check("rst_y_vld",   32'(y_vld),   0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: all request, requester 0 first
    req = 3'b111;
    din = 3'b101;
    cycle();
    check("t1_gnt",    32'(gnt),   1);
    check("t1_y_vld0", 32'(y_vld), 0);
    cycle();
    check("t1_gnt_hold", 32'(gnt),   1);
    check("t1_y",        32'(y),     1);
    check("t1_y_vld",    32'(y_vld), 1);

    // 2: back-to-back hand-offs
    req = 3'b110;
    cycle();
    check("t2_gnt1",    32'(gnt),     2);
    check("t2_gnt_vld", 32'(gnt_vld), 1);
    req = 3'b100;
    cycle();
    check("t2_gnt2", 32'(gnt), 4);

    // 3: drop to idle, y holds while din toggles
    cycle();
    check("t3_y_own2", 32'(y), 1);
    req = 3'b000;
    cycle();
    check("t3_gnt_idle", 32'(gnt),     0);
    check("t3_vld_idle", 32'(gnt_vld), 0);
    check("t3_y_last",   32'(y),       1);
    for (int i = 0; i < 3; i++) begin
      din = ~din;
      cycle();
      check("t3_y_hold",   32'(y),     1);
      check("t3_y_vld_lo", 32'(y_vld), 0);
    end

    // 4: two holders, timeout rotation or permanent hold
    din = 3'b011;
    req = 3'b011;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 9; i++) begin
      e4 = (i < 4 || i == 8) ? 3'b001 : 3'b010;
      cycle();
      check("t4_rotate", 32'(gnt), 32'(e4));
    end
`else
    for (int i = 0; i < 12; i++) begin
      e4 = 3'b001;
      cycle();
      check("t4_hold", 32'(gnt), 32'(e4));
    end
`endif
    req = 3'b000;
    cycle();
    cycle();

    // 5: asynchronous reset mid-grant
    req = 3'b100;
    cycle();
    check("t5_gnt_pre", 32'(gnt), 4);
    #10 rst_n = 1'b0;
    #1;
    check("t5_async_gnt", 32'(gnt),     0);
    check("t5_async_vld", 32'(gnt_vld), 0);
    req = 3'b101;
    #20 rst_n = 1'b1;
    cycle();
    check("t5_restart", 32'(gnt), 1);
    req = 3'b000;
    cycle();
    cycle();

    // 6: asynchronous random toggling against the scoreboard
    foreach (wait_c[k]) wait_c[k] = 0;
    for (int i = 0; i < 3000; i++) begin
      #1;
      if (i % 37 == 0)  begin req[0] = ~req[0]; din[0*DW +: DW] = DW'($urandom); end
      if (i % 57 == 0)  begin req[1] = ~req[1]; din[1*DW +: DW] = DW'($urandom); end
      if (i % 317 == 0) begin req[2] = ~req[2]; din[2*DW +: DW] = DW'($urandom); end
      if (i % 13 == 0)  din = DINW'($urandom);
      #9;
      if ((i + 1) % 10 == 0) begin
        sb_compare();
        max_w = 0;
        for (int k = 0; k < N; k++) begin
          wait_c[k] = (req[k] && !gnt[k]) ? wait_c[k] + 1 : 0;
          if (wait_c[k] > max_w) max_w = wait_c[k];
        end
`ifdef ARB_TIMEOUT_EN
        check("t6_starve", 32'(max_w <= N * MH), 1);
`endif
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
